// File: rtl/paddle_driver_if.sv
// Paddle driver bundle: player buttons and recenter in, game tick and paddle
// centres out.
//
// There is no valid/ready pair on this bundle. Inputs are level signals that
// the slave samples on every rising clk edge. Outputs are registered, change
// only on rising clk edges, and are always valid once clr has been released.
interface paddle_driver_if;
  logic       btn1_up;
  logic       btn1_down;
  logic       btn1_left;
  logic       btn1_right;
  logic       btn2_up;
  logic       btn2_down;
  logic       btn2_left;
  logic       btn2_right;
  logic       recenter;
  logic       clk_cursor;
  logic       prev_clk_cursor;
  logic [9:0] ball1_x;
  logic [9:0] ball1_y;
  logic [9:0] ball2_x;
  logic [9:0] ball2_y;

  // Game-side driver: presses buttons and requests recentering.
  modport master (
    output btn1_up, btn1_down, btn1_left, btn1_right,
    output btn2_up, btn2_down, btn2_left, btn2_right,
    output recenter,
    input  clk_cursor, prev_clk_cursor,
    input  ball1_x, ball1_y, ball2_x, ball2_y
  );

  // Paddle driver itself.
  modport slave (
    input  btn1_up, btn1_down, btn1_left, btn1_right,
    input  btn2_up, btn2_down, btn2_left, btn2_right,
    input  recenter,
    output clk_cursor, prev_clk_cursor,
    output ball1_x, ball1_y, ball2_x, ball2_y
  );
endinterface

// File: rtl/paddle_driver.sv
// Two-player paddle driver.
// A divided game tick (clk_cursor) produces one move pulse per tick period.
// Each of the eight buttons is synchronized and debounced; on a move pulse
// every paddle axis steps by STEP pixels toward the pressed direction and is
// clamped to its inclusive bounds. recenter sends both paddles home.
module paddle_driver #(
  parameter int unsigned TICK_HALF = 416667,
  parameter int unsigned DEBOUNCE  = 250000,
  parameter int unsigned STEP      = 4,
  parameter int unsigned Y_MIN     = 121,
  parameter int unsigned Y_MAX     = 421,
  parameter int unsigned P1_XMIN   = 244,
  parameter int unsigned P1_XMAX   = 454,
  parameter int unsigned P2_XMIN   = 474,
  parameter int unsigned P2_XMAX   = 684,
  parameter int unsigned P1_X0     = 300,
  parameter int unsigned P2_X0     = 628,
  parameter int unsigned Y0        = 271
) (
  input  logic           clk,
  input  logic           clr,
  paddle_driver_if.slave bus
);

  localparam int unsigned TW = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;
  localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_HALF - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

  localparam logic [9:0] HOME_P1_X = 10'(P1_X0);
  localparam logic [9:0] HOME_P2_X = 10'(P2_X0);
  localparam logic [9:0] HOME_Y    = 10'(Y0);

  // Bit positions inside the packed button vector.
  localparam int B1_UP    = 0;
  localparam int B1_DOWN  = 1;
  localparam int B1_LEFT  = 2;
  localparam int B1_RIGHT = 3;
  localparam int B2_UP    = 4;
  localparam int B2_DOWN  = 5;
  localparam int B2_LEFT  = 6;
  localparam int B2_RIGHT = 7;

  // ---------------------------------------------------------------------------
  // Clamped stepping helpers. The increment test is written as c+STEP > hi so
  // that hi-STEP can never underflow; the decrement test as c < lo+STEP so the
  // subtraction below it never wraps.
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] step_dec(input logic [9:0] c,
                                          input int unsigned lo);
    logic [9:0] r;
    if (32'(c) < lo + STEP) r = 10'(lo);
    else                    r = c - 10'(STEP);
    return r;
  endfunction

  function automatic logic [9:0] step_inc(input logic [9:0] c,
                                          input int unsigned hi);
    logic [9:0] r;
    if (32'(c) + STEP > hi) r = 10'(hi);
    else                    r = c + 10'(STEP);
    return r;
  endfunction

  // One axis: a single pressed direction moves, both or neither hold.
  function automatic logic [9:0] axis_next(input logic [9:0] c,
                                           input logic dec_b,
                                           input logic inc_b,
                                           input int unsigned lo,
                                           input int unsigned hi);
    logic [9:0] r;
    r = c;
    if (dec_b && !inc_b)      r = step_dec(c, lo);
    else if (inc_b && !dec_b) r = step_inc(c, hi);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Game tick
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_q, tick_d;
  logic          cursor_q, cursor_d;
  logic          prev_q;
  logic          move_pulse;

  // Next tick count and cursor level; cursor flips on each terminal count.
  always_comb begin
    tick_d   = tick_q + TW'(1);
    cursor_d = cursor_q;
    if (tick_q == TICK_LAST) begin
      tick_d   = '0;
      cursor_d = ~cursor_q;
    end
  end

  // Tick counter, cursor and its one-clk delayed copy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_q   <= '0;
      cursor_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      cursor_q <= cursor_d;
      prev_q   <= cursor_q;
    end
  end

  // Rising edge of the cursor, one clk wide.
  assign move_pulse = cursor_q & ~prev_q;

  // ---------------------------------------------------------------------------
  // Button synchronizers and debouncers
  // ---------------------------------------------------------------------------
  logic [7:0]    btn_raw;
  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    deb_q, deb_d;
  logic [DW-1:0] dcnt_q [8];
  logic [DW-1:0] dcnt_d [8];

  assign btn_raw = {bus.btn2_right, bus.btn2_left, bus.btn2_down, bus.btn2_up,
                    bus.btn1_right, bus.btn1_left, bus.btn1_down, bus.btn1_up};

  // Per button: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                       dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  // Two-flop synchronizer followed by debounced state and counters.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 8; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 8; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Paddle positions
  // ---------------------------------------------------------------------------
  logic [9:0] b1x_q, b1y_q, b2x_q, b2y_q;
  logic [9:0] b1x_d, b1y_d, b2x_d, b2y_d;

  // Candidate positions; only differ from the registers on a move pulse.
  always_comb begin
    b1x_d = b1x_q;
    b1y_d = b1y_q;
    b2x_d = b2x_q;
    b2y_d = b2y_q;
    if (move_pulse) begin
      b1x_d = axis_next(b1x_q, deb_q[B1_LEFT], deb_q[B1_RIGHT], P1_XMIN, P1_XMAX);
      b1y_d = axis_next(b1y_q, deb_q[B1_UP],   deb_q[B1_DOWN],  Y_MIN,   Y_MAX);
      b2x_d = axis_next(b2x_q, deb_q[B2_LEFT], deb_q[B2_RIGHT], P2_XMIN, P2_XMAX);
      b2y_d = axis_next(b2y_q, deb_q[B2_UP],   deb_q[B2_DOWN],  Y_MIN,   Y_MAX);
    end
  end

  // Position registers; recenter wins over a coincident move.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      b1x_q <= HOME_P1_X;
      b1y_q <= HOME_Y;
      b2x_q <= HOME_P2_X;
      b2y_q <= HOME_Y;
    end else if (bus.recenter) begin
      b1x_q <= HOME_P1_X;
      b1y_q <= HOME_Y;
      b2x_q <= HOME_P2_X;
      b2y_q <= HOME_Y;
    end else begin
      b1x_q <= b1x_d;
      b1y_q <= b1y_d;
      b2x_q <= b2x_d;
      b2y_q <= b2y_d;
    end
  end

  assign bus.clk_cursor      = cursor_q;
  assign bus.prev_clk_cursor = prev_q;
  assign bus.ball1_x         = b1x_q;
  assign bus.ball1_y         = b1y_q;
  assign bus.ball2_x         = b2x_q;
  assign bus.ball2_y         = b2y_q;

endmodule

// File: tb/tb_paddle_driver.sv
// Bench for paddle_driver with a small tick and debounce so every behaviour
// shows up within a few thousand cycles.
module tb_paddle_driver;

  localparam int TH = 4;
  localparam int DB = 3;
  localparam int ST = 4;
  localparam int YMIN = 121, YMAX = 421;
  localparam int X1MIN = 244, X1MAX = 454, X2MIN = 474, X2MAX = 684;
  localparam int X1H = 300, X2H = 628, YH = 271;

  logic clk = 1'b0;
  logic clr;
  paddle_driver_if bus();

  paddle_driver #(.TICK_HALF(TH), .DEBOUNCE(DB), .STEP(ST)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus state; bit order: p1 up,down,left,right then p2 up,down,left,right.
  logic [7:0] btn_v = '0;
  logic       rc_v  = 1'b0;

  // Scoreboard: {clk_cursor, prev, b1x, b1y, b2x, b2y}
  logic [41:0] exp_q[$];

  // ---------------------------------------------------------------- reference
  int   m_n = 0;
  bit   m_cursor = 0, m_prev = 0;
  bit [7:0] m_deb = '0, m_h1 = '0, m_h2 = '0;
  int   m_run [8];
  int   m_pos [4];   // b1x, b1y, b2x, b2y

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_home();
    m_pos[0] = X1H; m_pos[1] = YH; m_pos[2] = X2H; m_pos[3] = YH;
  endtask

  initial begin
    model_home();
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    forever begin
      @(posedge clk);
      if (clr) begin
        m_n = 0; m_cursor = 0; m_prev = 0;
        m_deb = '0; m_h1 = '0; m_h2 = '0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        model_home();
      end else begin
        if (rc_v) begin
          model_home();
        end else if (m_cursor && !m_prev) begin
          for (int p = 0; p < 2; p++) begin
            int dy, dx;
            dy = int'(m_deb[4*p+1]) - int'(m_deb[4*p+0]);
            dx = int'(m_deb[4*p+3]) - int'(m_deb[4*p+2]);
            m_pos[2*p+1] = clampi(m_pos[2*p+1] + dy*ST, YMIN, YMAX);
            m_pos[2*p]   = clampi(m_pos[2*p] + dx*ST,
                                  (p == 0) ? X1MIN : X2MIN,
                                  (p == 0) ? X1MAX : X2MAX);
          end
        end
        // debouncer sees the raw level from two edges back
        for (int i = 0; i < 8; i++) begin
          if (m_h2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
              m_deb[i] = m_h2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_h2 = m_h1;
        m_h1 = btn_v;
        m_n++;
        m_prev   = m_cursor;
        m_cursor = ((m_n / TH) % 2) == 1;
      end
      exp_q.push_back({m_cursor, m_prev, 10'(m_pos[0]), 10'(m_pos[1]),
                       10'(m_pos[2]), 10'(m_pos[3])});
    end
  end

  // ---------------------------------------------------------------- monitor
  initial begin
    logic [41:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus.clk_cursor, bus.prev_clk_cursor, bus.ball1_x, bus.ball1_y,
             bus.ball2_x, bus.ball2_y};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL cycle t=%0t got cur=%b prev=%b b1=(%0d,%0d) b2=(%0d,%0d) exp cur=%b prev=%b b1=(%0d,%0d) b2=(%0d,%0d)",
                   $time, g[41], g[40], g[39:30], g[29:20], g[19:10], g[9:0],
                   e[41], e[40], e[39:30], e[29:20], e[19:10], e[9:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive();
    bus.btn1_up    = btn_v[0];
    bus.btn1_down  = btn_v[1];
    bus.btn1_left  = btn_v[2];
    bus.btn1_right = btn_v[3];
    bus.btn2_up    = btn_v[4];
    bus.btn2_down  = btn_v[5];
    bus.btn2_left  = btn_v[6];
    bus.btn2_right = btn_v[7];
    bus.recenter   = rc_v;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Step until the current cycle is a move-pulse cycle, with a bounded wait.
  task automatic wait_pulse();
    int k;
    k = 0;
    while (!(m_cursor && !m_prev) && k < 4*TH) begin
      cycles(1);
      k++;
    end
    if (!(m_cursor && !m_prev)) begin
      total++;
      bad++;
      $display("FAIL wait_pulse got=no_pulse exp=pulse within %0d cycles", 4*TH);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    clr = 1'b1;
    drive();
    cycles(3);
    check("rst_b1x", bus.ball1_x, X1H);
    check("rst_b2x", bus.ball2_x, X2H);
    check("rst_cursor", bus.clk_cursor, 0);
    clr = 1'b0;

    // idle: tick runs, paddles stay home
    cycles(40);
    check("idle_b1y", bus.ball1_y, YH);
    check("idle_b2y", bus.ball2_y, YH);

    // player 1 right held across 8 pulses
    wait_pulse();
    btn_v = 8'h08; drive();
    cycles(64);
    btn_v = '0; drive();
    cycles(20);
    check("right_b1x", bus.ball1_x, 332);
    check("right_b2x", bus.ball2_x, X2H);

    // player 2 up until clamped at Y_MIN
    btn_v = 8'h10; drive();
    cycles(45 * 2 * TH);
    btn_v = '0; drive();
    cycles(10);
    check("up_clamp_b2y", bus.ball2_y, YMIN);

    // player 1 up+down+left: y holds, x clamps at left bound
    btn_v = 8'h07; drive();
    cycles(25 * 2 * TH);
    btn_v = '0; drive();
    cycles(10);
    check("hold_b1y", bus.ball1_y, YH);
    check("left_clamp_b1x", bus.ball1_x, X1MIN);

    // 2-clk glitch on player 1 down: nothing moves
    wait_pulse();
    btn_v = 8'h02; drive();
    cycles(2);
    btn_v = '0; drive();
    cycles(30);
    check("glitch2_b1y", bus.ball1_y, YH);

    // 5-clk glitch: one accepted press, one step down
    wait_pulse();
    btn_v = 8'h02; drive();
    cycles(5);
    btn_v = '0; drive();
    cycles(30);
    check("glitch5_b1y", bus.ball1_y, YH + ST);

    // recenter on a pulse cycle while buttons are still held
    btn_v = 8'h28; drive();
    cycles(6 * 2 * TH);
    wait_pulse();
    rc_v = 1'b1; drive();
    cycles(1);
    rc_v = 1'b0; drive();
    check("rc_b1x", bus.ball1_x, X1H);
    check("rc_b1y", bus.ball1_y, YH);
    check("rc_b2x", bus.ball2_x, X2H);
    check("rc_b2y", bus.ball2_y, YH);
    check("rc_cursor", bus.clk_cursor, 1);
    check("rc_prev", bus.prev_clk_cursor, 1);
    btn_v = '0; drive();
    cycles(10);

    // asynchronous clr in the middle of movement
    btn_v = 8'h2a; drive();
    cycles(30);
    clr = 1'b1;
    #1;
    check("aclr_b1y", bus.ball1_y, YH);
    check("aclr_b2y", bus.ball2_y, YH);
    check("aclr_cursor", bus.clk_cursor, 0);
    cycles(3);
    btn_v = '0; drive();
    clr = 1'b0;
    cycles(5);

    // randomized button patterns with occasional recenter
    repeat (60) begin
      btn_v = 8'($urandom_range(0, 255));
      rc_v  = ($urandom_range(0, 7) == 0);
      drive();
      cycles(1);
      rc_v = 1'b0; drive();
      cycles($urandom_range(1, 16));
    end
    btn_v = '0; drive();
    cycles(20);

    check("sb_drained", (exp_q.size() <= 1) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
